fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage: owns the architectural PC register, consumes the `new_pc` next-address value and drives a single-outstanding-request instruction-memory port. Fetched words are delivered into the IF/ID pipeline register (`ifid_pc`, `ifid_instr`, `ifid_valid`), which feeds decode and the next-PC computation. Handles decode stalls and branch/jump redirects, squashing wrong-path fetches.

## Interface

- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0013: instruction placed in IF/ID on reset and flush (`addi x0,x0,0`).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `new_pc`  in  32  next fetch address from next-PC logic; sampled when the PC advances.
- `redirect`  in  1  control transfer resolved in ID; flush IF/ID and fetch `new_pc`.
- `stall`  in  1  hazard stall; hold IF/ID and PC.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch address, equal to `pc`.
- `imem_ready`  in  1  memory accepts request this cycle.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  32  instruction word, valid with `imem_rvalid`.
- `pc`  out  32  current fetch PC (registered).
- `pc_plus_4`  out  32  `pc + 4`, modulo 2^32.
- `ifid_pc`, `ifid_instr`  out  32 each  IF/ID register contents.
- `ifid_valid`  out  1  IF/ID holds a real instruction.

## Operation

- States: REQ (`imem_req`=1, `imem_addr`=`pc`), WAIT (request accepted, awaiting `imem_rvalid`), HOLD (response captured in 32-bit buffer while `stall`=1). One-bit `drop` flag marks an in-flight wrong-path response.
- REQ: `imem_req && imem_ready` -> WAIT. `imem_addr` stays stable until accepted except on redirect.
- WAIT, `imem_rvalid`=1:
  - `drop`=1: discard data, clear `drop`, -> REQ.
  - `stall`=1: data to buffer, -> HOLD.
  - else: `ifid_instr`<=`imem_rdata`, `ifid_pc`<=`pc`, `ifid_valid`<=1, `pc`<=`new_pc`, -> REQ.
- HOLD, `stall`=0: load IF/ID from buffer (with `ifid_pc`<=`pc`), `pc`<=`new_pc`, -> REQ.
- IF/ID each cycle with no delivery: `stall`=1 holds all three fields; otherwise `ifid_valid`<=0 (bubble; `ifid_pc`/`ifid_instr` keep last value).
- Redirect (priority over stall and delivery; below reset): `ifid_valid`<=0, `ifid_instr`<=`NOP_INSTR`, `pc`<=`new_pc`, then by state:
  - REQ, `imem_ready`=0: stay REQ; new address presented next cycle.
  - REQ, `imem_ready`=1: old request accepted; `drop`<=1, -> WAIT.
  - WAIT, `imem_rvalid`=0: `drop`<=1, stay WAIT.
  - WAIT, `imem_rvalid`=1: discard data, `drop`<=0, -> REQ.
  - HOLD: discard buffer, -> REQ.
- `imem_rvalid` outside WAIT is a protocol error; ignored.
- `pc_plus_4` combinational from `pc`; 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing

- Reset (cycle with `rst`=1): `pc`=`RESET_PC`, `pc_plus_4`=`RESET_PC`+4, `ifid_pc`=0, `ifid_instr`=`NOP_INSTR`, `ifid_valid`=0, `drop`=0, state REQ. `imem_req`=1 from first cycle after reset deasserts. Reset mid-transaction abandons it; a late `imem_rvalid` after reset (state REQ) is ignored.
- One outstanding request max; no new request while in WAIT/HOLD.
- Zero-wait memory (`imem_ready`=1, `imem_rvalid` the cycle after acceptance): one instruction per 2 cycles; `ifid_valid` rises 2 cycles after `imem_req` first asserts.
- `pc` changes only on delivery, HOLD release, redirect or reset.
- Redirect: `ifid_valid`=0 the next cycle; first correct-path instruction in IF/ID no earlier than 2 cycles after the redirect cycle (plus drain of any dropped response).

## Test plan

- Reset: `rst` 2 cycles with `RESET_PC`=32'h100 -> `pc`=32'h100, `pc_plus_4`=32'h104, `ifid_valid`=0, `ifid_instr`=32'h13, `imem_req`=1 next cycle with `imem_addr`=32'h100.
- Sequential fetch, zero-wait memory, `new_pc`=`pc_plus_4`: IF/ID receives PCs 0x100, 0x104, 0x108 every 2 cycles with matching rdata; `ifid_valid` alternates 1/0.
- Stall: `stall`=1 for 3 cycles spanning `imem_rvalid` -> IF/ID and `pc` frozen, no new `imem_req`; on release buffered word appears in IF/ID next cycle.
- Redirect in WAIT before response (`new_pc`=32'h200): response with wrong-path data discarded, next `imem_addr`=32'h200, `ifid_valid`=0 until 0x200's instruction arrives.
- Redirect in same cycle as `imem_rvalid`, and in REQ with `imem_ready`=1 -> former discards data immediately, latter sets `drop` and discards next response; both next fetch `new_pc`.
- Wrap: `pc`=32'hFFFF_FFFC -> `pc_plus_4`=0; with `new_pc`=`pc_plus_4`, next `imem_addr`=0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response port of the fetch stage.
// One outstanding request at a time: imem_req/imem_addr are held until
// imem_ready, and the word comes back later qualified by imem_rvalid.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: architectural PC, a single-outstanding imem
// request port and the IF/ID pipeline register. A response that arrives
// while decode is stalled is parked in a one-word buffer; redirects flush
// IF/ID and mark any request already in flight as wrong-path (drop).
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  new_pc,
  input  logic         redirect,
  input  logic         stall,
  fetch_unit_if.master imem,
  output logic [31:0]  pc,
  output logic [31:0]  pc_plus_4,
  output logic [31:0]  ifid_pc,
  output logic [31:0]  ifid_instr,
  output logic         ifid_valid
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic [31:0] hold_buf_q, hold_buf_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic        deliver;
  logic [31:0] deliver_word;

  // Next-state, PC and IF/ID update; redirect overrides stall and delivery.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    hold_buf_d   = hold_buf_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    // No delivery: a stalled decode keeps its instruction, otherwise a bubble.
    ifid_valid_d = stall ? ifid_valid_q : 1'b0;
    deliver      = 1'b0;
    deliver_word = imem.imem_rdata;

    if (redirect) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
      pc_d         = new_pc;
      case (state_q)
        S_REQ: begin
          // The old address is accepted this cycle; its data is wrong-path.
          if (imem.imem_ready) begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d  = 1'b1;
          end
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem.imem_ready) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else if (stall) begin
              hold_buf_d = imem.imem_rdata;
              state_d    = S_HOLD;
            end else begin
              deliver = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            deliver      = 1'b1;
            deliver_word = hold_buf_q;
          end
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end

    if (deliver) begin
      ifid_instr_d = deliver_word;
      ifid_pc_d    = pc_q;
      ifid_valid_d = 1'b1;
      pc_d         = new_pc;
      state_d      = S_REQ;
    end
  end

  // Control, PC and IF/ID registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      ifid_pc_q    <= 32'h0000_0000;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  // Stall buffer is pure data; it is only read in HOLD after being written.
  always_ff @(posedge clk) begin
    hold_buf_q <= hold_buf_d;
  end

  assign imem.imem_req  = (state_q == S_REQ);
  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;
  assign pc_plus_4      = pc_q + 32'd4;
  assign ifid_pc        = ifid_pc_q;
  assign ifid_instr     = ifid_instr_q;
  assign ifid_valid     = ifid_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus, a memory responder with
// programmable ready/latency, a transaction-level reference model compared
// every cycle, and literal expectations at the interesting points.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, redirect, stall;
  logic [31:0] new_pc;
  logic [31:0] pc, pc_plus_4, ifid_pc, ifid_instr;
  logic        ifid_valid;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .new_pc     (new_pc),
    .redirect   (redirect),
    .stall      (stall),
    .imem       (bus),
    .pc         (pc),
    .pc_plus_4  (pc_plus_4),
    .ifid_pc    (ifid_pc),
    .ifid_instr (ifid_instr),
    .ifid_valid (ifid_valid)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 0;

  // stimulus knobs
  bit          k_rst = 1, k_redir = 0, k_stall = 0, k_ready = 0, k_npc_abs = 0;
  logic [31:0] k_npc = 32'h0;
  int          k_delay = 1;

  // memory responder
  bit          r_pend = 0, r_fire = 0;
  int          r_cnt = 0;
  logic [31:0] r_addr = 32'h0;
  logic        s_req;
  logic [31:0] s_addr;

  // reference model (transaction view)
  logic [31:0] m_pc = 32'h0, m_ifid_pc = 32'h0, m_ifid_instr = 32'h0;
  bit          m_ifid_valid = 0;
  bit          m_busy = 0, m_wrong = 0, m_held = 0;
  logic [31:0] m_held_word = 32'h0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_0000;
  endfunction

  function automatic bit m_req();
    return !m_busy && !m_held;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic m_deliver(input logic [31:0] w);
    m_ifid_pc    = m_pc;
    m_ifid_instr = w;
    m_ifid_valid = 1;
    m_pc         = new_pc;
  endtask

  // Advance the model by one clock using the inputs applied this cycle.
  task automatic m_step();
    bit acc, got;
    if (rst) begin
      m_pc = RST_PC; m_ifid_pc = 32'h0; m_ifid_instr = NOP; m_ifid_valid = 0;
      m_busy = 0; m_wrong = 0; m_held = 0;
      return;
    end
    acc = m_req() && bus.imem_ready;
    got = m_busy && bus.imem_rvalid;
    if (redirect) begin
      m_ifid_valid = 0;
      m_ifid_instr = NOP;
      m_pc         = new_pc;
      m_held       = 0;
      if (acc) begin
        m_busy = 1; m_wrong = 1;
      end else if (got) begin
        m_busy = 0; m_wrong = 0;
      end else if (m_busy) begin
        m_wrong = 1;
      end
    end else begin
      if (!stall) m_ifid_valid = 0;
      if (acc) begin
        m_busy = 1; m_wrong = 0;
      end
      if (got) begin
        m_busy = 0;
        if (m_wrong) m_wrong = 0;
        else if (stall) begin
          m_held = 1; m_held_word = bus.imem_rdata;
        end else m_deliver(bus.imem_rdata);
      end else if (m_held && !stall) begin
        m_held = 0;
        m_deliver(m_held_word);
      end
    end
  endtask

  task automatic compare_model();
    check("pc", pc, m_pc);
    check("pc_plus_4", pc_plus_4, m_pc + 32'd4);
    check("imem_req", {31'h0, bus.imem_req}, {31'h0, m_req()});
    if (m_req()) check("imem_addr", bus.imem_addr, m_pc);
    check("ifid_valid", {31'h0, ifid_valid}, {31'h0, m_ifid_valid});
    check("ifid_pc", ifid_pc, m_ifid_pc);
    check("ifid_instr", ifid_instr, m_ifid_instr);
  endtask

  // One clock: apply inputs at the falling edge, update model/responder at
  // the rising edge, compare at the next falling edge.
  task automatic tick();
    rst      = k_rst;
    redirect = k_redir;
    stall    = k_stall;
    new_pc   = k_npc_abs ? k_npc : m_pc + 32'd4;
    r_fire   = r_pend && (r_cnt == 0);
    bus.imem_ready  = k_ready;
    bus.imem_rvalid = r_fire;
    bus.imem_rdata  = r_fire ? instr_of(r_addr) : 32'hDEAD_BEEF;
    s_req  = bus.imem_req;
    s_addr = bus.imem_addr;
    @(posedge clk);
    m_step();
    if (r_fire) r_pend = 0;
    else if (r_pend) r_cnt--;
    if (s_req === 1'b1 && k_ready) begin
      r_pend = 1; r_addr = s_addr; r_cnt = k_delay - 1;
    end
    if (rst) chk_en = 1;
    @(negedge clk);
    if (chk_en) compare_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Run until the responder will return data in the next cycle (bounded).
  task automatic wait_rsp();
    int i;
    i = 0;
    while (!(r_pend && r_cnt == 0) && i < 20) begin
      tick();
      i++;
    end
    check("wait_rsp", {31'h0, r_pend && r_cnt == 0}, 32'h1);
  endtask

  task automatic redirect_to(input logic [31:0] a);
    k_redir = 1; k_npc_abs = 1; k_npc = a;
    tick();
    k_redir = 0; k_npc_abs = 0;
  endtask

  initial begin
    rst = 1; redirect = 0; stall = 0; new_pc = 32'h0;
    bus.imem_ready = 0; bus.imem_rvalid = 0; bus.imem_rdata = 32'h0;

    // reset
    ticks(2);
    check("rst_pc", pc, 32'h100);
    check("rst_pc4", pc_plus_4, 32'h104);
    check("rst_valid", {31'h0, ifid_valid}, 32'h0);
    check("rst_instr", ifid_instr, 32'h13);
    check("rst_ifid_pc", ifid_pc, 32'h0);
    k_rst = 0; k_ready = 1; k_delay = 1;
    check("first_req", {31'h0, bus.imem_req}, 32'h1);
    check("first_addr", bus.imem_addr, 32'h100);

    // sequential zero-wait fetch
    tick();
    check("seq_wait_noreq", {31'h0, bus.imem_req}, 32'h0);
    tick();
    check("seq0_valid", {31'h0, ifid_valid}, 32'h1);
    check("seq0_pc", ifid_pc, 32'h100);
    check("seq0_instr", ifid_instr, 32'h1357_0100);
    tick();
    check("seq_bubble", {31'h0, ifid_valid}, 32'h0);
    tick();
    check("seq1_pc", ifid_pc, 32'h104);
    ticks(2);
    check("seq2_pc", ifid_pc, 32'h108);
    check("seq2_next_pc", pc, 32'h10C);

    // stall spanning the response
    tick();
    k_stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", pc, 32'h10C);
      check("stall_noreq", {31'h0, bus.imem_req}, 32'h0);
      check("stall_ifid_pc", ifid_pc, 32'h108);
    end
    k_stall = 0;
    tick();
    check("unstall_valid", {31'h0, ifid_valid}, 32'h1);
    check("unstall_pc", ifid_pc, 32'h10C);
    check("unstall_instr", ifid_instr, 32'h1357_010C);

    // redirect while waiting for a slow response
    k_delay = 3;
    tick();
    redirect_to(32'h200);
    check("rw_pc", pc, 32'h200);
    check("rw_instr", ifid_instr, 32'h13);
    wait_rsp();
    tick();
    check("rw_req", {31'h0, bus.imem_req}, 32'h1);
    check("rw_addr", bus.imem_addr, 32'h200);
    check("rw_valid", {31'h0, ifid_valid}, 32'h0);
    k_delay = 1;
    ticks(2);
    check("rw_deliver", ifid_pc, 32'h200);
    check("rw_deliver_instr", ifid_instr, 32'h1357_0200);

    // redirect in the same cycle as the response
    tick();
    wait_rsp();
    redirect_to(32'h300);
    check("rv_addr", bus.imem_addr, 32'h300);
    check("rv_req", {31'h0, bus.imem_req}, 32'h1);
    ticks(2);
    check("rv_deliver", ifid_pc, 32'h300);

    // redirect in REQ while the old address is accepted
    redirect_to(32'h400);
    check("ra_pc", pc, 32'h400);
    check("ra_noreq", {31'h0, bus.imem_req}, 32'h0);
    tick();
    check("ra_addr", bus.imem_addr, 32'h400);
    check("ra_valid", {31'h0, ifid_valid}, 32'h0);
    ticks(2);
    check("ra_deliver", ifid_pc, 32'h400);

    // redirect in REQ with memory not ready
    k_ready = 0;
    redirect_to(32'h500);
    check("rn_addr", bus.imem_addr, 32'h500);
    k_ready = 1;
    ticks(2);
    check("rn_deliver", ifid_pc, 32'h500);

    // redirect while a word is parked by a stall
    tick();
    k_stall = 1;
    tick();
    redirect_to(32'h600);
    k_stall = 0;
    check("rh_addr", bus.imem_addr, 32'h600);
    check("rh_req", {31'h0, bus.imem_req}, 32'h1);
    ticks(2);
    check("rh_deliver", ifid_pc, 32'h600);

    // PC wrap
    k_ready = 0;
    redirect_to(32'hFFFF_FFFC);
    check("wrap_pc4", pc_plus_4, 32'h0);
    k_ready = 1;
    ticks(2);
    check("wrap_ifid_pc", ifid_pc, 32'hFFFF_FFFC);
    check("wrap_addr", bus.imem_addr, 32'h0);

    // reset mid-transaction, late response ignored
    k_delay = 3;
    tick();
    k_rst = 1; k_ready = 0;
    tick();
    k_rst = 0;
    ticks(2);
    check("late_valid", {31'h0, ifid_valid}, 32'h0);
    check("late_instr", ifid_instr, 32'h13);
    check("late_pc", pc, 32'h100);
    check("late_req", {31'h0, bus.imem_req}, 32'h1);
    k_ready = 1; k_delay = 1;
    ticks(2);
    check("post_rst_deliver", ifid_pc, 32'h100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
